// File: rtl/sram_ctrl.sv
// Two-port round-robin controller for an asynchronous SRAM: sequences CS/WE/OE
// through SETUP, ACCESS and HOLD with an IDLE turnaround cycle between accesses.

module sram_ctrl_chk (
    input logic clk,
    input logic rst,
    input logic ram_we_n,
    input logic ram_oe_n,
    input logic ack0,
    input logic ack1
);

    // Strobe exclusivity and single-ack invariants
    always @(posedge clk) begin
        if (!rst) begin
            assert (ram_we_n || ram_oe_n) else $error("OE and WE both active");
            assert (!(ack0 && ack1)) else $error("ack0 and ack1 both active");
        end
    end

endmodule

module sram_ctrl #(
    parameter int AddressSize = 4,
    parameter int WordSize    = 8,
    parameter int WaitCycles  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0,
    input  logic                   req1,
    input  logic                   we0,
    input  logic                   we1,
    input  logic [AddressSize-1:0] addr0,
    input  logic [AddressSize-1:0] addr1,
    input  logic [WordSize-1:0]    wdata0,
    input  logic [WordSize-1:0]    wdata1,
    output logic                   ack0,
    output logic                   ack1,
    output logic [WordSize-1:0]    rdata,
    output logic                   busy,
    output logic [AddressSize-1:0] ram_addr,
    output logic [WordSize-1:0]    ram_dout,
    output logic                   ram_doe,
    input  logic [WordSize-1:0]    ram_din,
    output logic                   ram_cs_n,
    output logic                   ram_we_n,
    output logic                   ram_oe_n
);

    generate
        if (WaitCycles < 1 || WaitCycles > 15) begin : g_bad_wait_cycles
            $error("sram_ctrl: WaitCycles must lie in 1..15");
        end
    endgenerate

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    localparam logic [3:0] WAIT_LOAD = 4'(WaitCycles - 1);

    logic [1:0]             state_r;
    logic [3:0]             cnt_r;
    logic                   rr_r;
    logic                   gnt_r;
    logic                   we_r;
    logic                   pick_s;
    logic                   sel_we_s;
    logic [AddressSize-1:0] sel_addr_s;
    logic [WordSize-1:0]    sel_wdata_s;

    // Round-robin pick: rr_r names the port preferred when both request
    always_comb begin
        pick_s = 1'b0;
        if (req0 && req1) begin
            pick_s = rr_r;
        end else if (req1) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
    end

    // Steer the picked requester's command
    always_comb begin
        sel_we_s    = we0;
        sel_addr_s  = addr0;
        sel_wdata_s = wdata0;
        if (pick_s) begin
            sel_we_s    = we1;
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end else begin
            sel_we_s    = we0;
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end
    end

    // Transaction sequencer; every RAM pin and handshake output is a flop
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= 4'd0;
            rr_r     <= 1'b0;
            gnt_r    <= 1'b0;
            we_r     <= 1'b0;
            ram_cs_n <= 1'b1;
            ram_we_n <= 1'b1;
            ram_oe_n <= 1'b1;
            ram_doe  <= 1'b0;
            ram_addr <= '0;
            ram_dout <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata    <= '0;
            busy     <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state_r)
                IDLE: begin
                    ram_we_n <= 1'b1;
                    if (req0 || req1) begin
                        state_r  <= SETUP;
                        gnt_r    <= pick_s;
                        we_r     <= sel_we_s;
                        ram_addr <= sel_addr_s;
                        ram_cs_n <= 1'b0;
                        busy     <= 1'b1;
                        if (sel_we_s) begin
                            ram_dout <= sel_wdata_s;
                            ram_doe  <= 1'b1;
                            ram_oe_n <= 1'b1;
                        end else begin
                            ram_doe  <= 1'b0;
                            ram_oe_n <= 1'b0;
                        end
                    end else begin
                        ram_cs_n <= 1'b1;
                        ram_oe_n <= 1'b1;
                        ram_doe  <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                SETUP: begin
                    state_r <= ACCESS;
                    cnt_r   <= WAIT_LOAD;
                    if (we_r) begin
                        ram_we_n <= 1'b0;
                    end else begin
                        ram_we_n <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt_r == 4'd0) begin
                        // Last ACCESS edge: sample the pad, release strobes, ack
                        state_r  <= HOLD;
                        ram_we_n <= 1'b1;
                        ram_oe_n <= 1'b1;
                        rr_r     <= ~gnt_r;
                        ack0     <= ~gnt_r;
                        ack1     <= gnt_r;
                        if (!we_r) begin
                            rdata <= ram_din;
                        end else begin
                            rdata <= rdata;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                HOLD: begin
                    state_r  <= IDLE;
                    ram_cs_n <= 1'b1;
                    ram_doe  <= 1'b0;
                    busy     <= 1'b0;
                end
                default: begin
                    state_r  <= IDLE;
                    ram_cs_n <= 1'b1;
                    ram_we_n <= 1'b1;
                    ram_oe_n <= 1'b1;
                    ram_doe  <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    sram_ctrl_chk u_chk (
        .clk      (clk),
        .rst      (rst),
        .ram_we_n (ram_we_n),
        .ram_oe_n (ram_oe_n),
        .ack0     (ack0),
        .ack1     (ack1)
    );

endmodule
